bcd2bin_seq_ctrl: RTL and testbench



---
 rtl/bcd2bin_seq_ctrl_if.sv | 29 ++
 rtl/bcd2bin_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_bcd2bin_seq_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_ctrl_if.sv
// Request/grant/result bundle between the two operand front-ends and the
// shared BCD-to-binary converter.
interface bcd2bin_seq_ctrl_if #(
    parameter int DIGITS = 2
);
    localparam int BCD_W = 4 * DIGITS;

    logic             req_a;
    logic [BCD_W-1:0] bcd_a;
    logic             req_b;
    logic [BCD_W-1:0] bcd_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] binary;
    logic             err;
    logic             src;

    modport master (
        output req_a, bcd_a, req_b, bcd_b,
        input  gnt_a, gnt_b, busy, done, binary, err, src
    );

    modport slave (
        input  req_a, bcd_a, req_b, bcd_b,
        output gnt_a, gnt_b, busy, done, binary, err, src
    );
endinterface

// File: rtl/bcd2bin_seq_ctrl.sv
// Two-requester BCD-to-binary converter: shift-right / subtract-3, one bit per clock.
// Define BCD_RR_ARB_EN for round-robin tie-break; otherwise A has fixed priority.
module bcd2bin_seq_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd2bin_seq_ctrl_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BCD_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BCD_W - 1);

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tag_q, tag_d;
    logic [BCD_W-1:0] binary_q, binary_d;
    logic             err_q, err_d;
    logic             src_q, src_d;
    logic [BCD_W-1:0] w_q, w_d;
    logic [BCD_W-1:0] r_q, r_d;
    logic             win_a, win_b;
`ifdef BCD_RR_ARB_EN
    logic             rr_q, rr_d;
`endif

    function automatic logic bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // One step: {W,R} >> 1, then every W digit >= 8 drops by 3 (a halved 10s weight).
    function automatic logic [2*BCD_W-1:0] shift_step(input logic [BCD_W-1:0] w,
                                                      input logic [BCD_W-1:0] r);
        logic [2*BCD_W-1:0] wr;
        wr = {w, r} >> 1;
        for (int i = 0; i < DIGITS; i++)
            if (wr[BCD_W+4*i +: 4] >= 4'd8)
                wr[BCD_W+4*i +: 4] = wr[BCD_W+4*i +: 4] - 4'd3;
        return wr;
    endfunction

    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
`ifdef BCD_RR_ARB_EN
        if (bus.req_a && (!bus.req_b || !rr_q)) win_a = 1'b1;
        else if (bus.req_b)                     win_b = 1'b1;
`else
        if (bus.req_a)      win_a = 1'b1;
        else if (bus.req_b) win_b = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tag_q    <= 1'b0;
            binary_q <= '0;
            err_q    <= 1'b0;
            src_q    <= 1'b0;
`ifdef BCD_RR_ARB_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            binary_q <= binary_d;
            err_q    <= err_d;
            src_q    <= src_d;
`ifdef BCD_RR_ARB_EN
            rr_q     <= rr_d;
`endif
        end
    end

    // Working registers are fully rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        w_q <= w_d;
        r_q <= r_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_a || win_b) state_d = CHECK;
            CHECK:   state_d = bad_digit(w_q) ? DONE : SHIFT;
            SHIFT:   if (cnt_q == LAST_SHIFT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_d      = w_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        binary_d = binary_q;
        err_d    = err_q;
        src_d    = src_q;
`ifdef BCD_RR_ARB_EN
        rr_d     = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_a) begin
                    w_d   = bus.bcd_a;
                    tag_d = 1'b0;
                end else if (win_b) begin
                    w_d   = bus.bcd_b;
                    tag_d = 1'b1;
                end
`ifdef BCD_RR_ARB_EN
                if (win_a)      rr_d = 1'b1;
                else if (win_b) rr_d = 1'b0;
`endif
            end
            CHECK: begin
                r_d   = '0;
                cnt_d = '0;
                if (bad_digit(w_q)) begin
                    binary_d = '0;
                    err_d    = 1'b1;
                    src_d    = tag_q;
                end
            end
            SHIFT: begin
                {w_d, r_d} = shift_step(w_q, r_q);
                cnt_d      = cnt_q + 1'b1;
                // Results are loaded on the way into DONE so they are visible during it.
                if (cnt_q == LAST_SHIFT) begin
                    binary_d = r_d;
                    err_d    = 1'b0;
                    src_d    = tag_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.gnt_a  = (state_q == IDLE) && win_a;
        bus.gnt_b  = (state_q == IDLE) && win_b;
        bus.busy   = (state_q != IDLE);
        bus.done   = (state_q == DONE);
        bus.binary = binary_q;
        bus.err    = err_q;
        bus.src    = src_q;
    end
endmodule

// File: tb/tb_bcd2bin_seq_ctrl.sv
// Scoreboard bench for bcd2bin_seq_ctrl: stimulus pushes expected results at grant,
// a monitor pops and compares on every done strobe.
module tb_bcd2bin_seq_ctrl;
    localparam int DIGITS = 2;
    localparam int BCD_W  = 4 * DIGITS;
`ifdef BCD_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [BCD_W-1:0] bin;
        logic             err;
        logic             src;
        int               cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    bcd2bin_seq_ctrl_if #(.DIGITS(DIGITS)) ifc ();

    bcd2bin_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ifc.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done at cycle %0d required=no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("binary",  int'(ifc.binary), int'(mon_e.bin));
                chk("err",     int'(ifc.err),    int'(mon_e.err));
                chk("src",     int'(ifc.src),    int'(mon_e.src));
                chk("latency", cyc,              mon_e.cyc);
            end
        end
    end

    task automatic push(input logic [BCD_W-1:0] bin, input bit e, input bit s, input int gc);
        exp_t x;
        x.bin = bin;
        x.err = e;
        x.src = s;
        x.cyc = gc + (e ? 2 : 2 + BCD_W);
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input bit b, output int gc);
        gc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((b ? ifc.gnt_b : ifc.gnt_a) === 1'b1) begin
                gc = cyc;
                break;
            end
        end
        checks++;
        if (gc < 0) begin
            errors++;
            $display("FAIL gnt_timeout actual=no grant required=grant to %s", b ? "B" : "A");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb.size());
        end
        sb.delete();
    endtask

    task automatic conv(input bit b, input logic [BCD_W-1:0] bcd,
                        input logic [BCD_W-1:0] exp_bin, input bit e);
        int gc;
        @(posedge clk); #1;
        if (b) begin ifc.bcd_b = bcd; ifc.req_b = 1'b1; end
        else   begin ifc.bcd_a = bcd; ifc.req_a = 1'b1; end
        wait_gnt(b, gc);
        if (gc >= 0) push(exp_bin, e, b, gc);
        @(posedge clk); #1;
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;
        drain();
    endtask

    task automatic tie_test();
        bit exp_b;
        bit got;
        @(posedge clk); #1;
        ifc.bcd_a = 8'h12;
        ifc.bcd_b = 8'h34;
        ifc.req_a = 1'b1;
        ifc.req_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_b = RR && (k == 1);
            got   = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if ((ifc.gnt_a | ifc.gnt_b) === 1'b1) begin got = 1'b1; break; end
            end
            chk("tie_gnt_b", int'(ifc.gnt_b), int'(exp_b));
            chk("tie_gnt_a", int'(ifc.gnt_a), int'(!exp_b && got));
            if (got) push(exp_b ? 8'h22 : 8'h0C, 1'b0, exp_b, cyc);
            @(posedge clk);
        end
        #1;
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;
        drain();
    endtask

    task automatic holdoff_test();
        int gc, gcb, dc;
        bit bad;
        @(posedge clk); #1;
        ifc.bcd_a = 8'h42;
        ifc.req_a = 1'b1;
        wait_gnt(1'b0, gc);
        if (gc >= 0) push(8'h2A, 1'b0, 1'b0, gc);
        @(posedge clk); #1;
        ifc.req_a = 1'b0;
        ifc.bcd_b = 8'h99;
        ifc.req_b = 1'b1;
        bad = 1'b0;
        dc  = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.gnt_b === 1'b1) bad = 1'b1;
            if (ifc.done === 1'b1) begin dc = cyc; break; end
        end
        chk("holdoff_gnt_b", int'(bad), 0);
        wait_gnt(1'b1, gcb);
        chk("gnt_b_cycle", gcb, dc + 1);
        if (gcb >= 0) push(8'h63, 1'b0, 1'b1, gcb);
        @(posedge clk); #1;
        ifc.req_b = 1'b0;
        drain();
    endtask

    task automatic reset_test();
        int gc;
        @(posedge clk); #1;
        ifc.bcd_a = 8'h77;
        ifc.req_a = 1'b1;
        wait_gnt(1'b0, gc);
        @(posedge clk); #1;
        ifc.req_a = 1'b0;
        for (int i = 0; i < 20 && cyc < gc + 5; i++) @(negedge clk);
        chk("busy_in_shift", int'(ifc.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",   int'(ifc.busy),   0);
        chk("rst_done",   int'(ifc.done),   0);
        chk("rst_binary", int'(ifc.binary), 0);
        chk("rst_err",    int'(ifc.err),    0);
        chk("rst_src",    int'(ifc.src),    0);
        chk("rst_gnt_a",  int'(ifc.gnt_a),  0);
        chk("rst_gnt_b",  int'(ifc.gnt_b),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_idle", int'(ifc.busy), 0);
    endtask

    initial begin
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;
        ifc.bcd_a = '0;
        ifc.bcd_b = '0;
        #1;
        chk("init_gnt_a",  int'(ifc.gnt_a),  0);
        chk("init_gnt_b",  int'(ifc.gnt_b),  0);
        chk("init_busy",   int'(ifc.busy),   0);
        chk("init_done",   int'(ifc.done),   0);
        chk("init_binary", int'(ifc.binary), 0);
        chk("init_err",    int'(ifc.err),    0);
        chk("init_src",    int'(ifc.src),    0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(ifc.busy), 0);

        conv(1'b0, 8'h42, 8'h2A, 1'b0);
        conv(1'b0, 8'h00, 8'h00, 1'b0);
        conv(1'b0, 8'h5A, 8'h00, 1'b1);
        conv(1'b0, 8'h07, 8'h07, 1'b0);
        conv(1'b1, 8'h99, 8'h63, 1'b0);
        tie_test();
        holdoff_test();
        reset_test();
        conv(1'b0, 8'h36, 8'h24, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=bench completion");
        $fatal(1, "watchdog expired");
    end
endmodule
